rv32i_mem_arbiter: RTL and testbench

Shares one 32-bit single-port memory between the core's instruction-fetch requester and its load/store requester. Each requester uses a req/ack handshake; the memory side uses req/ack with wait states. The block sits between the rv32i core's iaddr/inst and daddr/din/dout/wr_mask/wr_en ports and a unified RAM or bus slave. A watchdog ends any transaction the memory never acknowledges.

---
 rtl/rv32i_mem_arbiter.sv | 177 +++++++++++++++++
 tb/tb_rv32i_mem_arbiter.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv32i_mem_arbiter.sv
// rv32i_mem_arbiter: shares one single-port memory between the instruction-fetch
// requester and the load/store requester of the rv32i core.
//   - req/ack handshake on both requester sides, req/ack with wait states on memory
//   - watchdog aborts a memory access that is never acknowledged (TIMEOUT=0 disables)
//   - every output is driven straight from a flop
// Build option: define RV32I_ARB_RR_EN to alternate grants on simultaneous requests.
// Without it, data always wins over instruction fetch.
module rv32i_mem_arbiter #(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned CNT_W   = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  // instruction fetch side
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic [31:0] i_rdata,
  output logic        i_ack,
  output logic        i_err,
  // load/store side
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_mask,
  output logic [31:0] d_rdata,
  output logic        d_ack,
  output logic        d_err,
  // memory side
  output logic        m_req,
  output logic        m_we,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  output logic [3:0]  m_mask,
  input  logic [31:0] m_rdata,
  input  logic        m_ack,
  // status
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, BUS_I, BUS_D, RESP} state_e;

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timeout_hit;
  logic             any_req;
  logic             pick_d;

  logic [31:0]      i_rdata_q, d_rdata_q;
  logic             i_ack_q, d_ack_q, i_err_q, d_err_q;
  logic             m_req_q, m_we_q;
  logic [31:0]      m_addr_q, m_wdata_q;
  logic [3:0]       m_mask_q;
  logic             busy_q;

`ifdef RV32I_ARB_RR_EN
  // 1 = data side was granted last, 0 = instruction side
  logic             last_d_q;
  assign pick_d = d_req && (!i_req || !last_d_q);
`else
  assign pick_d = d_req;
`endif

  assign any_req = i_req | d_req;

  // Watchdog next value: saturating increment so it can never wrap back to 0.
  always_comb begin
    cnt_d = cnt_q;
    if (cnt_q != {CNT_W{1'b1}})
      cnt_d = cnt_q + 1'b1;
  end

  // Timeout fires in the BUS cycle whose count reaches TIMEOUT; m_ack in that
  // same cycle still takes priority in the state machine below.
  assign timeout_hit = (TIMEOUT != 0) && (cnt_d == CNT_W'(TIMEOUT));

  // Arbiter state machine with all outputs registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
      i_ack_q   <= 1'b0;
      d_ack_q   <= 1'b0;
      i_err_q   <= 1'b0;
      d_err_q   <= 1'b0;
      m_req_q   <= 1'b0;
      m_we_q    <= 1'b0;
      m_addr_q  <= '0;
      m_wdata_q <= '0;
      m_mask_q  <= '0;
      busy_q    <= 1'b0;
`ifdef RV32I_ARB_RR_EN
      last_d_q  <= 1'b0;
`endif
    end else begin
      // ack/err are single-cycle pulses by default
      i_ack_q <= 1'b0;
      d_ack_q <= 1'b0;
      i_err_q <= 1'b0;
      d_err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          cnt_q <= '0;
          if (any_req) begin
            m_req_q <= 1'b1;
            busy_q  <= 1'b1;
`ifdef RV32I_ARB_RR_EN
            last_d_q <= pick_d;
`endif
            if (pick_d) begin
              m_we_q    <= d_we;
              m_addr_q  <= d_addr;
              m_wdata_q <= d_wdata;
              m_mask_q  <= d_we ? d_mask : 4'b0000;
              state_q   <= BUS_D;
            end else begin
              m_we_q    <= 1'b0;
              m_addr_q  <= i_addr;
              m_wdata_q <= '0;
              m_mask_q  <= 4'b0000;
              state_q   <= BUS_I;
            end
          end
        end
        BUS_I, BUS_D: begin
          cnt_q <= cnt_d;
          if (m_ack || timeout_hit) begin
            m_req_q <= 1'b0;
            m_we_q  <= 1'b0;
            state_q <= RESP;
            if (state_q == BUS_I) begin
              i_ack_q   <= 1'b1;
              i_err_q   <= !m_ack;
              i_rdata_q <= m_ack ? m_rdata : 32'h0;
            end else begin
              d_ack_q <= 1'b1;
              d_err_q <= !m_ack;
              // a completed store leaves the last load data in place
              if (!m_ack)
                d_rdata_q <= 32'h0;
              else if (!m_we_q)
                d_rdata_q <= m_rdata;
            end
          end
        end
        RESP: begin
          cnt_q   <= '0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          cnt_q   <= '0;
          m_req_q <= 1'b0;
          m_we_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign i_rdata = i_rdata_q;
  assign i_ack   = i_ack_q;
  assign i_err   = i_err_q;
  assign d_rdata = d_rdata_q;
  assign d_ack   = d_ack_q;
  assign d_err   = d_err_q;
  assign m_req   = m_req_q;
  assign m_we    = m_we_q;
  assign m_addr  = m_addr_q;
  assign m_wdata = m_wdata_q;
  assign m_mask  = m_mask_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_rv32i_mem_arbiter.sv
// Scoreboard bench for rv32i_mem_arbiter: each request pushes its expected memory
// command and response; a monitor pops and compares when an ack appears.
module tb_rv32i_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_req = 1'b0;
  logic [31:0] i_addr = '0;
  logic [31:0] i_rdata;
  logic        i_ack, i_err;
  logic        d_req = 1'b0, d_we = 1'b0;
  logic [31:0] d_addr = '0, d_wdata = '0;
  logic [3:0]  d_mask = '0;
  logic [31:0] d_rdata;
  logic        d_ack, d_err;
  logic        m_req, m_we;
  logic [31:0] m_addr, m_wdata;
  logic [3:0]  m_mask;
  logic [31:0] m_rdata = '0;
  logic        m_ack = 1'b0;
  logic        busy;

  rv32i_mem_arbiter #(.TIMEOUT(4), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ack(i_ack), .i_err(i_err),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_mask(d_mask),
    .d_rdata(d_rdata), .d_ack(d_ack), .d_err(d_err),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_mask(m_mask),
    .m_rdata(m_rdata), .m_ack(m_ack), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_d;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  mask;
    logic [31:0] rdata;
    bit          keep;   // store: d_rdata must keep the previous load value
    bit          err;
    int          lat;    // 0 = latency not checked
    int          t0;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0, failures = 0, cyc = 0, ack_dly = 1;
  logic [31:0] md_rdata = '0;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // memory contents: fixed instruction at 0x100, address-derived elsewhere
  function automatic logic [31:0] mdata(logic [31:0] a);
    return (a == 32'h100) ? 32'h0050_0093 : (a ^ 32'h5A5A_0000);
  endfunction

  function automatic exp_t mk(bit is_d, bit we, logic [31:0] addr, logic [31:0] wdata,
                              logic [3:0] mask, bit err, int lat);
    exp_t e;
    e.is_d = is_d; e.we = we; e.addr = addr; e.wdata = wdata; e.mask = mask;
    e.err = err; e.lat = lat; e.t0 = cyc;
    e.keep = is_d && we && !err;
    e.rdata = err ? 32'h0 : mdata(addr);
    return e;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // memory model: ack in the ack_dly-th cycle of m_req (0 = never), junk data otherwise
  initial begin
    int bc;
    bc = 0;
    forever begin
      @(posedge clk); #1;
      bc = m_req ? bc + 1 : 0;
      if (m_req && ack_dly != 0 && bc == ack_dly) begin
        m_ack = 1'b1; m_rdata = mdata(m_addr);
      end else begin
        m_ack = 1'b0; m_rdata = $urandom;
      end
    end
  end

  // monitor: memory command on m_req rise, response on ack
  initial begin
    exp_t        e;
    logic [31:0] er;
    bit          pend_idle, mreq_prev;
    pend_idle = 0; mreq_prev = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        mreq_prev = 0; pend_idle = 0;
      end else begin
        if (pend_idle) begin
          chk("busy_idle", busy, 0);
          chk("ack_pulse", {i_ack, d_ack}, 0);
          pend_idle = 0;
        end
        if (m_req && !mreq_prev) begin
          if (sb.size() == 0) chk("unexp_mreq", 1, 0);
          else begin
            chk("m_addr", m_addr, sb[0].addr);
            chk("m_we", m_we, sb[0].we);
            chk("m_mask", m_mask, sb[0].we ? sb[0].mask : 4'h0);
            if (sb[0].we) chk("m_wdata", m_wdata, sb[0].wdata);
            chk("busy_bus", busy, 1);
          end
        end
        mreq_prev = m_req;
        if (i_ack || d_ack) begin
          if (sb.size() == 0) chk("unexp_ack", {i_ack, d_ack}, 0);
          else begin
            e = sb.pop_front();
            chk("ack_sel", {i_ack, d_ack}, e.is_d ? 2'b01 : 2'b10);
            er = e.keep ? md_rdata : e.rdata;
            if (e.is_d) begin
              chk("d_rdata", d_rdata, er);
              chk("d_err", d_err, e.err);
              md_rdata = er;
            end else begin
              chk("i_rdata", i_rdata, er);
              chk("i_err", i_err, e.err);
            end
            chk("resp_mreq", m_req, 0);
            chk("resp_mwe", m_we, 0);
            chk("busy_resp", busy, 1);
            if (e.lat != 0) chk("latency", cyc - e.t0, e.lat);
            pend_idle = 1;
          end
        end
      end
    end
  end

  // single request with a given memory delay; called at posedge+1
  task automatic xact(bit is_d, bit we, logic [31:0] addr, logic [31:0] wdata,
                      logic [3:0] mask, int dly, bit err);
    bit seen;
    seen = 0;
    ack_dly = dly;
    sb.push_back(mk(is_d, we, addr, wdata, mask, err, (err || dly == 0) ? 5 : dly + 1));
    if (is_d) begin
      d_we = we; d_addr = addr; d_wdata = wdata; d_mask = mask; d_req = 1'b1;
    end else begin
      i_addr = addr; i_req = 1'b1;
    end
    for (int n = 0; n < 50 && !seen; n++) begin
      @(negedge clk);
      seen = is_d ? d_ack : i_ack;
    end
    if (!seen) begin
      chk("ack_timeout", 0, 1);
      sb.delete();
    end
    @(posedge clk); #1;
    i_req = 1'b0; d_req = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  // one requester doing 4 back-to-back loads, re-raising right after each ack
  task automatic rounds(bit is_d);
    bit seen;
    for (int r = 0; r < 4; r++) begin
      if (is_d) begin
        d_we = 1'b0; d_mask = 4'hF; d_addr = 32'h3000 + r * 4; d_req = 1'b1;
      end else begin
        i_addr = 32'h4000 + r * 4; i_req = 1'b1;
      end
      seen = 0;
      for (int n = 0; n < 100 && !seen; n++) begin
        @(negedge clk);
        seen = is_d ? d_ack : i_ack;
      end
      if (!seen) chk(is_d ? "d_round_timeout" : "i_round_timeout", 0, 1);
      @(posedge clk); #1;
    end
    if (is_d) d_req = 1'b0;
    else i_req = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1);
  end

  initial begin
    // reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_i_rdata", i_rdata, 0);
    chk("rst_d_rdata", d_rdata, 0);
    chk("rst_m_addr", m_addr, 0);
    chk("rst_m_wdata", m_wdata, 0);
    chk("rst_ctrl", {i_ack, d_ack, i_err, d_err, m_req, m_we, busy, m_mask}, 0);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;

    // fetch with ack 3 cycles into the memory access
    xact(0, 0, 32'h100, 32'h0, 4'h0, 3, 0);

    // simultaneous requesters, 4 rounds each
    ack_dly = 1;
`ifdef RV32I_ARB_RR_EN
    for (int r = 0; r < 4; r++) begin
      sb.push_back(mk(1, 0, 32'h3000 + r * 4, 0, 4'hF, 0, 0));
      sb.push_back(mk(0, 0, 32'h4000 + r * 4, 0, 4'h0, 0, 0));
    end
`else
    for (int r = 0; r < 4; r++) sb.push_back(mk(1, 0, 32'h3000 + r * 4, 0, 4'hF, 0, 0));
    for (int r = 0; r < 4; r++) sb.push_back(mk(0, 0, 32'h4000 + r * 4, 0, 4'h0, 0, 0));
`endif
    fork
      rounds(1);
      rounds(0);
    join
    chk("arb_drained", sb.size(), 0);
    repeat (2) @(posedge clk);
    #1;

    // store acked in the first memory cycle
    xact(1, 1, 32'h2004, 32'h0000_AB00, 4'b0010, 1, 0);
    // load that the memory never acks: watchdog abort
    xact(1, 0, 32'h2008, 32'h0, 4'hF, 0, 1);
    // ack in the very cycle the watchdog would fire
    xact(1, 0, 32'h200C, 32'h0, 4'hF, 4, 0);

    // asynchronous reset in the middle of a data access
    ack_dly = 0;
    sb.push_back(mk(1, 0, 32'h5000, 0, 4'h0, 0, 0));
    d_we = 1'b0; d_addr = 32'h5000; d_mask = 4'h0; d_req = 1'b1;
    for (int n = 0; n < 10 && !m_req; n++) @(negedge clk);
    chk("pre_rst_mreq", m_req, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mreq_async", m_req, 0);
    chk("rst_busy_async", busy, 0);
    chk("rst_no_dack", d_ack, 0);
    sb.delete();
    d_req = 1'b0;
    md_rdata = '0;
    @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    xact(0, 0, 32'h600, 32'h0, 4'h0, 2, 0);
    chk("sb_empty", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
